// File: rtl/zcr_pkg.sv
// Shared types and constants for the zero-crossing stimulus synthesizer.
package zcr_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned WINDOW_SIZE_DEF = 64;
  localparam int unsigned AMPLITUDE_DEF   = 32'h4000;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3 of the register
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/zcr_lfsr.sv
// 8-bit Fibonacci LFSR with enable, used as low-order dither for zcr_synth.
module zcr_lfsr
  import zcr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/zcr_synth.sv
// Emits one window of +/-AMPLITUDE samples with exactly N sign changes spread by a Bresenham accumulator.
// Define ZCR_SYNTH_DITHER_EN to XOR an 8-bit LFSR into the low magnitude bits.
module zcr_synth
  import zcr_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned                WINDOW_SIZE = WINDOW_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0]      AMPLITUDE   = DATA_WIDTH'(AMPLITUDE_DEF),
  parameter int unsigned                CNT_W       = $clog2(WINDOW_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic                  cnt_valid,
  output logic                  cnt_ready,
  input  logic                  sample_en,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  window_start,
  output logic                  window_done,
  output logic                  busy
);

  localparam int unsigned      IDX_W    = $clog2(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] N_MAX    = CNT_W'(WINDOW_SIZE - 1);
  localparam logic [CNT_W:0]   D        = (CNT_W + 1)'(WINDOW_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW_SIZE - 1);

  state_t                 state, state_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [CNT_W:0]         acc, acc_d, acc_sum;
  logic [IDX_W-1:0]       idx, idx_d;
  logic                   sign, sign_d, sign_cur;
  logic [DATA_WIDTH-1:0]  sample_d;
  logic                   valid_d, start_d, done_d;
  logic [DATA_WIDTH-1:0]  mag;

`ifdef ZCR_SYNTH_DITHER_EN
  logic [7:0] lfsr_q;

  zcr_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    ((state == ST_RUN) && sample_en),
    .q     (lfsr_q)
  );

  assign mag = AMPLITUDE ^ {{(DATA_WIDTH - 8){1'b0}}, lfsr_q};
`else
  assign mag = AMPLITUDE;
`endif

  // Ready is masked while reset is held so no handshake can appear to complete during reset.
  assign cnt_ready = (state == ST_IDLE) && !reset;
  assign busy      = (state == ST_RUN);
  assign acc_sum   = acc + (CNT_W + 1)'(n_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    n_d      = n_q;
    acc_d    = acc;
    idx_d    = idx;
    sign_d   = sign;
    sign_cur = sign;
    sample_d = sample_out;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cnt_valid) begin
          n_d     = (cnt_in > N_MAX) ? N_MAX : cnt_in;
          acc_d   = '0;
          idx_d   = '0;
          sign_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_en) begin
          if (idx == '0) begin
            sign_cur = 1'b0;
          end else if (acc_sum >= D) begin
            sign_cur = ~sign;
            acc_d    = acc_sum - D;
          end else begin
            acc_d    = acc_sum;
          end
          sign_d   = sign_cur;
          sample_d = sign_cur ? ('0 - mag) : mag;
          valid_d  = 1'b1;
          start_d  = (idx == '0);
          done_d   = (idx == IDX_LAST);
          idx_d    = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      n_q          <= '0;
      acc          <= '0;
      idx          <= '0;
      sign         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      window_start <= 1'b0;
      window_done  <= 1'b0;
    end else begin
      state        <= state_d;
      n_q          <= n_d;
      acc          <= acc_d;
      idx          <= idx_d;
      sign         <= sign_d;
      sample_out   <= sample_d;
      sample_valid <= valid_d;
      window_start <= start_d;
      window_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_zcr_synth.sv
// Scoreboard bench for zcr_synth (WINDOW_SIZE=8): stimulus pushes expected windows, a monitor pops on sample_valid.
module tb_zcr_synth;

  localparam int DW = 16;
  localparam int WS = 8;
  localparam int CW = 4;
  localparam logic [DW-1:0] POS = 16'h4000;
  localparam logic [DW-1:0] NEG = 16'hC000;
`ifdef ZCR_SYNTH_DITHER_EN
  localparam logic [DW-1:0] MASK = 16'h8000;
`else
  localparam logic [DW-1:0] MASK = 16'hFFFF;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cnt_in;
  logic          cnt_valid;
  logic          cnt_ready;
  logic          sample_en;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          window_start;
  logic          window_done;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] sample;
    logic          start;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   vcyc[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  zcr_synth #(
    .DATA_WIDTH  (DW),
    .WINDOW_SIZE (WS),
    .AMPLITUDE   (16'h4000),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_in       (cnt_in),
    .cnt_valid    (cnt_valid),
    .cnt_ready    (cnt_ready),
    .sample_en    (sample_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .window_start (window_start),
    .window_done  (window_done),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // neg_mask bit i set means sample i is expected negative (hand-derived per count)
  task automatic start_window(input int cnt, input logic [7:0] neg_mask);
    int i;
    for (i = 0; i < 100; i++) begin
      if (cnt_ready) break;
      @(posedge clk); #1;
    end
    check("ready_before_handshake", cnt_ready, 1);
    for (int k = 0; k < WS; k++) begin
      sb_q.push_back('{sample: neg_mask[k] ? NEG : POS, start: (k == 0), done: (k == WS - 1)});
    end
    cnt_in    = CW'(cnt);
    cnt_valid = 1'b1;
    @(posedge clk); #1;
    cnt_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_low_after_accept", cnt_ready, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (cnt_ready && !busy && sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("window_drained", sb_q.size(), 0);
    check("idle_after_window", busy, 0);
  endtask

  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] last_exp;
    last_exp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_exp = '0;
        continue;
      end
      if (sample_valid) begin
        vcyc.push_back(cycle);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sample: got %0h expected no sample (t=%0t)", sample_out, $time);
        end else begin
          e = sb_q.pop_front();
          check("sample_value", sample_out & MASK, e.sample & MASK);
          check("window_start", window_start, e.start);
          check("window_done", window_done, e.done);
          last_exp = e.sample;
        end
      end else begin
        check("sample_hold", sample_out & MASK, last_exp & MASK);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit found;
    reset     = 1'b1;
    cnt_in    = '0;
    cnt_valid = 1'b0;
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt_ready", cnt_ready, 0);
    check("reset_sample_valid", sample_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_sample_out", sample_out, 0);
    check("reset_window_start", window_start, 0);
    check("reset_window_done", window_done, 0);
    reset = 1'b0;
    #1;
    check("ready_after_release", cnt_ready, 1);

    // sample_en in IDLE must produce nothing (monitor flags any stray pulse)
    sample_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ignores_sample_en", busy, 0);

    start_window(0, 8'h00); wait_idle();
    start_window(7, 8'hAA); wait_idle();
    start_window(3, 8'h98); wait_idle();

    // 200 truncates to 8 on the 4-bit port, still above the clamp of 7
    start_window(200, 8'hAA);
    cnt_in    = '0;
    cnt_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("run_ignores_cnt_valid_ready", cnt_ready, 0);
      check("run_ignores_cnt_valid_busy", busy, 1);
    end
    cnt_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (window_done) begin
        found = 1'b1;
        break;
      end
    end
    check("window_done_seen", found, 1);
    check("ready_with_window_done", cnt_ready, 1);
    check("busy_low_with_window_done", busy, 0);
    @(posedge clk); #1;
    wait_idle();

    // sample_en every third cycle, N=1
    sample_en = 1'b0;
    vcyc.delete();
    start_window(1, 8'h80);
    for (int k = 0; k < 30; k++) begin
      sample_en = (k % 3 == 0);
      @(posedge clk); #1;
    end
    sample_en = 1'b0;
    wait_idle();
    check("sparse_pulse_count", vcyc.size(), WS);
    for (int i = 1; i < vcyc.size(); i++) begin
      check("sparse_pulse_gap", vcyc[i] - vcyc[i-1], 3);
    end

    // reset just before sample 4 of an N=3 window, then replay
    sample_en = 1'b1;
    start_window(3, 8'h98);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (sb_q.size() == 4) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_sample_4", found, 1);
    reset = 1'b1;
    #1;
    check("abort_sample_out", sample_out, 0);
    check("abort_sample_valid", sample_valid, 0);
    check("abort_window_start", window_start, 0);
    check("abort_window_done", window_done, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt_ready", cnt_ready, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    start_window(3, 8'h98);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/zcr_synth.md
# zcr_synth

Generates one window of audio samples containing exactly a requested number of sign changes (zero crossings). It is the inverse of the zero-crossing-rate extractor: a count goes in and a sample stream comes out. It sits in the I2S audio path as a deterministic stimulus source for the ZCR feature path and the transmit side. Samples are paced by a frame-rate strobe from the I2S clocking logic.

## Interface
- DATA_WIDTH, 16, sample width (two's complement)
- WINDOW_SIZE, 64, samples per window (≥2)
- AMPLITUDE, 16'h4000, positive sample magnitude; must be >255 and <2^(DATA_WIDTH-1)
- CNT_W, $clog2(WINDOW_SIZE)+1, width of the count input

- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- cnt_in  input  CNT_W  requested crossings per window
- cnt_valid  input  1  cnt_in offered
- cnt_ready  output  1  block idle and accepting a count
- sample_en  input  1  frame strobe; one sample is produced per accepted strobe
- sample_out  output  DATA_WIDTH  generated sample
- sample_valid  output  1  one-cycle pulse, sample_out valid
- window_start  output  1  coincides with sample_valid of sample 0
- window_done  output  1  coincides with sample_valid of sample WINDOW_SIZE-1
- busy  output  1  window in progress

## Operation
- FSM has two states:
  - IDLE: cnt_ready=1. When cnt_valid=1, latch N = min(cnt_in, WINDOW_SIZE-1), clear acc and idx, set sign=+, go to RUN.
  - RUN: cnt_ready=0, busy=1. Each cycle with sample_en=1 emits sample idx, then increments idx. After sample WINDOW_SIZE-1 is emitted, return to IDLE.
- Crossing spread uses a Bresenham accumulator, with D = WINDOW_SIZE-1:
  - Sample 0 is always positive.
  - For idx ≥1: acc' = acc+N. If acc' ≥ D, toggle sign and acc ← acc'−D; otherwise acc ← acc'.
  - This produces exactly N toggles over the D sample pairs.
- acc width is CNT_W+1 bits. No overflow is possible because acc < D before each add.
- Sample value is +AMPLITUDE when sign=+ and −AMPLITUDE (two's complement) when sign=−. The MSB carries the sign.
- Each window restarts positive. The junction between windows is not part of a window's count.
- sample_en is ignored in IDLE. cnt_valid is ignored in RUN.

## Timing
- Reset values: cnt_ready=0 during reset, then 1 in IDLE from the first cycle after release. sample_out=0, sample_valid=0, window_start=0, window_done=0, busy=0. State=IDLE.
- Handshake accepted at edge T: RUN from T+1, so busy=1 and cnt_ready=0 after edge T.
- sample_en=1 sampled at edge E: sample_out, sample_valid, window_start and window_done are registered and valid after edge E, for one cycle.
- Gaps in sample_en hold state. Back-to-back sample_en gives one sample per cycle.
- window_done edge W: IDLE after W, so cnt_ready=1. A new count is accepted at W+1 at the earliest.
- sample_out holds its last value between pulses.
- Reset asserted mid-window: immediate abort, all outputs go to reset values, and the partial window is discarded.

## Configuration
- ZCR_SYNTH_DITHER_EN defined: an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4) advances once per emitted sample. Its value is XORed into bits [7:0] of the magnitude before the sign is applied. Sign and crossing count are unchanged.
- ZCR_SYNTH_DITHER_EN undefined: magnitude is exactly AMPLITUDE and no LFSR is instantiated.

## Structure
- Package zcr_pkg holds:
  - state enum (ST_IDLE, ST_RUN)
  - default DATA_WIDTH, WINDOW_SIZE and AMPLITUDE constants
  - LFSR seed and tap constant
- Sub-module zcr_lfsr (8-bit Fibonacci, with enable) is instantiated only under ZCR_SYNTH_DITHER_EN. Everything else is flat.

## Test plan
All scenarios use WINDOW_SIZE=8, AMPLITUDE=16'h4000, dither off unless stated, and sample_en=1 continuously unless stated.
- N=0 → eight samples of 16'h4000. window_start on sample 0, window_done on sample 7.
- N=7 → alternating 4000, C000, 4000, … with 7 MSB toggles.
- N=3 → signs + + + − − + + −; toggles at idx 3, 5, 7.
- cnt_in=200 → clamped to 7, alternating pattern. cnt_valid asserted during RUN is ignored, and cnt_ready rises after window_done.
- sample_en every third cycle, N=1 → only idx 7 negative. 8 sample_valid pulses spaced 3 cycles apart.
- Reset at sample 4 of an N=3 window → outputs zero. The next handshake (N=3) replays the N=3 pattern from sample 0. With dither on, the MSB sequence is identical to dither off.
